dco_tap_ctrl: RTL and testbench

Synchronous control sequencer for the ring-oscillator DCO. It turns a binary frequency code into the one-hot tap-select word (lambda) and the oscillator enable (en) that drive the NAND/delay-line ring.
It generalises the fixed 4-tap decoder to NTAPS taps and clamps out-of-range codes. It slew-limits code changes to one tap per STEP_WAIT cycles while the ring runs, and sequences enable/disable so lambda is never changed while the loop is being gated.
Runs on the reference clock; the DCO output is never used as a clock here.

---
 rtl/dco_tap_ctrl.sv | 151 +++++++++++++++
 tb/tb_dco_tap_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dco_tap_ctrl.sv
`default_nettype none
// ============================================================================
// dco_tap_ctrl : ring-DCO tap sequencer (code clamp, slew limit, en sequencing)
// Revision     : 1.0
// ============================================================================
module dco_tap_ctrl #(
  parameter int NTAPS     = 8,
  parameter int CODE_W    = 7,
  parameter int STEP_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_req,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic [NTAPS-1:0]  lambda,
  output logic              en,
  output logic [CODE_W-1:0] cur_code,
  output logic              busy,
  output logic              sat
);

  localparam int                CNT_W      = $clog2(STEP_WAIT + 1);
  localparam logic [CNT_W-1:0]  C_WAIT     = CNT_W'(STEP_WAIT);
  localparam logic [CNT_W-1:0]  C_WAIT_M1  = CNT_W'(STEP_WAIT - 1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
  localparam logic [CODE_W-1:0] C_MAX_CODE = CODE_W'(NTAPS - 1);
  localparam logic [CODE_W-1:0] C_CODE_ONE = CODE_W'(1);
  localparam logic [NTAPS-1:0]  C_ONE      = NTAPS'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CODE_W-1:0] r_target;

  logic              w_sat_in;
  logic [CODE_W-1:0] w_clamp;
  logic              w_xfer;

  assign w_sat_in = (code_in > C_MAX_CODE);
  assign w_clamp  = w_sat_in ? C_MAX_CODE : code_in;

  // Ready only where a new code can be applied without disturbing a ramp or gating sequence.
  assign code_ready = !rst && ((r_state == ST_IDLE) ||
                               ((r_state == ST_RUN) && (cur_code == r_target)));
  assign w_xfer     = code_valid && code_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_target <= '0;
      cur_code <= '0;
      lambda   <= C_ONE;
      en       <= 1'b0;
      busy     <= 1'b0;
      sat      <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_target <= w_clamp;
        sat      <= w_sat_in;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            cur_code <= w_clamp;
            lambda   <= C_ONE << w_clamp;
          end else if (r_target != cur_code) begin
            cur_code <= r_target;
            lambda   <= C_ONE << r_target;
          end
          // Loaded with the full wait so en rises STEP_WAIT+1 edges after the request.
          if (en_req) begin
            r_state <= ST_START;
            r_cnt   <= C_WAIT;
            busy    <= 1'b1;
          end
        end
        ST_START: begin
          if (!en_req) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= ST_RUN;
            en      <= 1'b1;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - C_CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!en_req) begin
            r_state <= ST_STOP;
            r_cnt   <= C_WAIT_M1;
            en      <= 1'b0;
            busy    <= 1'b1;
          end else if (w_xfer && (w_clamp != cur_code)) begin
            r_state <= ST_STEP;
            r_cnt   <= C_WAIT_M1;
            busy    <= 1'b1;
          end
        end
        ST_STEP: begin
          if (!en_req) begin
            r_state <= ST_STOP;
            r_cnt   <= C_WAIT_M1;
            en      <= 1'b0;
            busy    <= 1'b1;
          end else if (cur_code == r_target) begin
            r_state <= ST_RUN;
            busy    <= 1'b0;
          end else if (r_cnt == '0) begin
            r_cnt <= C_WAIT_M1;
            if (r_target > cur_code) begin
              cur_code <= cur_code + C_CODE_ONE;
              lambda   <= lambda << 1;
            end else begin
              cur_code <= cur_code - C_CODE_ONE;
              lambda   <= lambda >> 1;
            end
          end else begin
            r_cnt <= r_cnt - C_CNT_ONE;
          end
        end
        ST_STOP: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - C_CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          en      <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dco_tap_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dco_tap_ctrl : directed + random stimulus against a timing-rule model
// Revision        : 1.0
// ============================================================================
module tb_dco_tap_ctrl;

  localparam int NTAPS     = 8;
  localparam int CODE_W    = 7;
  localparam int STEP_WAIT = 4;

  localparam int M_OFF  = 0;
  localparam int M_WARM = 1;
  localparam int M_ON   = 2;
  localparam int M_SLEW = 3;
  localparam int M_COOL = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              en_req;
  logic [CODE_W-1:0] code_in;
  logic              code_valid;
  logic              code_ready;
  logic [NTAPS-1:0]  lambda;
  logic              en;
  logic [CODE_W-1:0] cur_code;
  logic              busy;
  logic              sat;

  int vectors     = 0;
  int miscompares = 0;

  // Model: mode, ring enable, applied/target code, and absolute cycle at which the pending action is due.
  int m_mode, m_cur, m_tgt, m_due, n_edge;
  bit m_en, m_sat;

  always #5 clk = ~clk;

  dco_tap_ctrl #(.NTAPS(NTAPS), .CODE_W(CODE_W), .STEP_WAIT(STEP_WAIT)) dut (
    .clk(clk), .rst(rst), .en_req(en_req), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .lambda(lambda), .en(en), .cur_code(cur_code),
    .busy(busy), .sat(sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    return !rst && ((m_mode == M_OFF) || ((m_mode == M_ON) && (m_cur == m_tgt)));
  endfunction

  task automatic model_edge();
    int  code_v;
    int  clamp;
    bit  xfer;
    code_v = int'(code_in);
    clamp  = (code_v > NTAPS - 1) ? NTAPS - 1 : code_v;
    xfer   = code_valid && model_ready();
    n_edge++;
    if (rst) begin
      m_mode = M_OFF; m_cur = 0; m_tgt = 0; m_en = 0; m_sat = 0; m_due = 0;
      return;
    end
    if (xfer) begin
      m_sat = (code_v > NTAPS - 1);
    end
    case (m_mode)
      M_OFF: begin
        if (xfer) begin m_cur = clamp; m_tgt = clamp; end
        else m_cur = m_tgt;
        if (en_req) begin m_mode = M_WARM; m_due = n_edge + STEP_WAIT + 1; end
      end
      M_WARM: begin
        if (!en_req) m_mode = M_OFF;
        else if (n_edge == m_due) begin m_mode = M_ON; m_en = 1; end
      end
      M_ON: begin
        if (xfer) m_tgt = clamp;
        if (!en_req) begin m_mode = M_COOL; m_en = 0; m_due = n_edge + STEP_WAIT; end
        else if (xfer && clamp != m_cur) begin m_mode = M_SLEW; m_due = n_edge + STEP_WAIT; end
      end
      M_SLEW: begin
        if (!en_req) begin m_mode = M_COOL; m_en = 0; m_due = n_edge + STEP_WAIT; end
        else if (m_cur == m_tgt) m_mode = M_ON;
        else if (n_edge == m_due) begin
          m_cur = (m_tgt > m_cur) ? m_cur + 1 : m_cur - 1;
          m_due = n_edge + STEP_WAIT;
        end
      end
      default: begin
        if (n_edge == m_due) m_mode = M_OFF;
      end
    endcase
  endtask

  // One clock: advance model on the edge, then compare every output 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("en",       32'(en),         32'(m_en));
    chk("cur_code", 32'(cur_code),   32'(m_cur));
    chk("lambda",   32'(lambda),     32'(1) << m_cur);
    chk("onehot",   32'($onehot(lambda)), 32'(1));
    chk("busy",     32'(busy),       32'((m_mode == M_WARM) || (m_mode == M_SLEW) || (m_mode == M_COOL)));
    chk("sat",      32'(sat),        32'(m_sat));
    chk("ready",    32'(code_ready), 32'(model_ready()));
  endtask

  initial begin
    m_mode = M_OFF; m_cur = 0; m_tgt = 0; m_due = 0; n_edge = 0; m_en = 0; m_sat = 0;
    rst = 1'b1; en_req = 1'b0; code_in = '0; code_valid = 1'b0;

    // Reset held three cycles
    repeat (3) cyc();
    chk("rst_lambda", 32'(lambda), 32'h01);
    chk("rst_ready",  32'(code_ready), 32'(0));
    rst = 1'b0;
    #1;
    chk("ready_after_release", 32'(code_ready), 32'(1));

    // Idle loads, including a clamped code
    code_in = 7'd5; code_valid = 1'b1;
    cyc();
    chk("idle_load5", 32'(lambda), 32'h20);
    code_in = 7'd12;
    cyc();
    chk("idle_clamp_cur", 32'(cur_code), 32'd7);
    chk("idle_clamp_sat", 32'(sat), 32'd1);
    code_in = 7'd5;
    cyc();
    code_valid = 1'b0;

    // Start: en rises STEP_WAIT+1 edges after the request is sampled
    en_req = 1'b1;
    cyc();
    for (int i = 1; i <= STEP_WAIT; i++) begin
      cyc();
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_en",   32'(en),   32'd0);
    end
    cyc();
    chk("start_en_up", 32'(en), 32'd1);

    // Ramp 5 -> 2
    code_in = 7'd2; code_valid = 1'b1;
    cyc();
    code_valid = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      if (k == 4)  chk("ramp_4", 32'(cur_code), 32'd4);
      if (k == 8)  chk("ramp_3", 32'(cur_code), 32'd3);
      if (k == 12) chk("ramp_2", 32'(cur_code), 32'd2);
      if (k == 13) chk("ramp_ready", 32'(code_ready), 32'd1);
    end

    // Back up to 5, then stop mid-ramp on the way down again
    code_in = 7'd5; code_valid = 1'b1;
    cyc();
    code_valid = 1'b0;
    repeat (13) cyc();
    code_in = 7'd2; code_valid = 1'b1;
    cyc();
    code_valid = 1'b0;
    repeat (4) cyc();
    en_req = 1'b0;
    cyc();
    chk("stop_en", 32'(en), 32'd0);
    for (int i = 0; i < STEP_WAIT; i++) begin
      if (i > 0) cyc();
      chk("stop_hold", 32'(lambda), 32'h10);
    end
    cyc();
    chk("stop_idle_busy", 32'(busy), 32'd0);
    cyc();
    chk("stop_pending_load", 32'(cur_code), 32'd2);

    // Reset during a ramp
    en_req = 1'b1;
    repeat (STEP_WAIT + 2) cyc();
    code_in = 7'd6; code_valid = 1'b1;
    cyc();
    code_valid = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_lambda", 32'(lambda), 32'h01);
    chk("midrst_en",     32'(en),     32'd0);
    rst = 1'b0;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 29) == 0) en_req = ~en_req;
      code_valid = ($urandom_range(0, 5) == 0);
      code_in    = ($urandom_range(0, 7) == 0) ? CODE_W'($urandom_range(8, 127))
                                               : CODE_W'($urandom_range(0, 7));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
